// File: rtl/multicycle_datapath.sv
// multicycle_datapath
// Multi-cycle RISC-V-style datapath. Each instruction walks through
// FETCH -> EXECUTE -> (MEMORY) -> WRITEBACK and shares a single memory port
// that uses a request/ready handshake. An external controller decodes the
// `instruction` output and supplies the control inputs.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   result_select       writeback source (ALU / load data / PC+4)
//   PC_select           next PC: 1 = PC+imm, 0 = PC+4
//   ALU_select          ALU operand B: 1 = immediate, 0 = rs2
//   reg_write           write rd during WRITEBACK
//   immediate_select    immediate format I/S/B/J
//   ALU_control         add/sub/and/or/slt
//   mem_load, mem_store instruction accesses memory (store wins if both set)
//   mem_read_data       memory return data
//   mem_ready           memory accepts/completes the current request
//   mem_request, mem_write, mem_address, mem_write_data   memory request
//   instruction         instruction register
//   zero                registered ALU result is zero
//   PC                  current program counter
//   ALU_result          registered ALU result
//   retire              one-cycle pulse in WRITEBACK
module multicycle_datapath #(
  parameter int XLEN = 32,
  parameter int REG_COUNT = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      result_select,
  input  logic            PC_select,
  input  logic            ALU_select,
  input  logic            reg_write,
  input  logic [1:0]      immediate_select,
  input  logic [2:0]      ALU_control,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] mem_read_data,
  input  logic            mem_ready,
  output logic            mem_request,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic [31:0]     instruction,
  output logic            zero,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] ALU_result,
  output logic            retire
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, EXECUTE, MEMORY, WRITEBACK} state_t;

  state_t state, next_state;

  logic [XLEN-1:0]   regs [REG_COUNT];
  logic [XLEN-1:0]   load_data;
  logic [IDX_W-1:0]  rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]   rs1_val, rs2_val, operand_b, imm, alu_next;
  logic [XLEN-1:0]   wb_value, pc_plus4;
  logic signed [31:0] imm32;
  logic              transfer_done;

  // Register indices wrap modulo REG_COUNT by keeping only the low bits.
  assign rs1_idx = instruction[15 +: IDX_W];
  assign rs2_idx = instruction[20 +: IDX_W];
  assign rd_idx  = instruction[7 +: IDX_W];

  assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];

  assign operand_b      = ALU_select ? imm : rs2_val;
  assign pc_plus4       = PC + XLEN'(4);
  assign zero           = (ALU_result == '0);
  assign mem_write_data = rs2_val;
  // mem_request is already forced low during reset, so a completion
  // can never be seen while reset is asserted.
  assign transfer_done  = mem_request && mem_ready;

  // Immediate assembly for the four formats; the 32-bit value is then
  // sign-extended to the datapath width.
  always_comb begin
    imm32 = '0;
    case (immediate_select)
      2'b00:   imm32 = {{20{instruction[31]}}, instruction[31:20]};
      2'b01:   imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      2'b10:   imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      default: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
    endcase
    imm = XLEN'(imm32);
  end

  // ALU; undefined opcodes produce zero.
  always_comb begin
    alu_next = '0;
    case (ALU_control)
      3'b000:  alu_next = rs1_val + operand_b;
      3'b001:  alu_next = rs1_val - operand_b;
      3'b010:  alu_next = rs1_val & operand_b;
      3'b011:  alu_next = rs1_val | operand_b;
      3'b101:  alu_next = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(operand_b))};
      default: alu_next = '0;
    endcase
  end

  // Writeback source; the reserved encoding falls back to the ALU result.
  always_comb begin
    wb_value = ALU_result;
    case (result_select)
      2'b01:   wb_value = load_data;
      2'b10:   wb_value = pc_plus4;
      default: wb_value = ALU_result;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // FSM next-state logic; the memory states hold until the handshake completes.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:     if (transfer_done) next_state = EXECUTE;
      EXECUTE:   next_state = (mem_load || mem_store) ? MEMORY : WRITEBACK;
      MEMORY:    if (transfer_done) next_state = WRITEBACK;
      WRITEBACK: next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  // FSM outputs. Request and retire are gated by reset so an in-flight
  // transaction is dropped in the very cycle reset is raised.
  always_comb begin
    mem_request = 1'b0;
    mem_write   = 1'b0;
    retire      = 1'b0;
    mem_address = (state == MEMORY) ? ALU_result : PC;
    if (!reset) begin
      case (state)
        FETCH:     mem_request = 1'b1;
        MEMORY: begin
          mem_request = 1'b1;
          mem_write   = mem_store;
        end
        WRITEBACK: retire = 1'b1;
        default: ;
      endcase
    end
  end

  // Architectural state updates, one phase per FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      PC          <= RESET_PC;
      instruction <= NOP;
      ALU_result  <= '0;
      load_data   <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH:   if (transfer_done) instruction <= mem_read_data[31:0];
        EXECUTE: ALU_result <= alu_next;
        MEMORY:  if (transfer_done) load_data <= mem_read_data;
        WRITEBACK: begin
          if (reg_write && (rd_idx != '0)) regs[rd_idx] <= wb_value;
          PC <= PC_select ? (PC + imm) : pc_plus4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Testbench for multicycle_datapath. Acts as the external controller
// (a small decoder for the handful of opcodes used) and as a word memory
// with a programmable number of wait states per request.
module tb_multicycle_datapath;

  typedef struct packed {
    logic [1:0] res_sel;
    logic       pc_sel;
    logic       alu_sel;
    logic       reg_wr;
    logic [1:0] imm_sel;
    logic [2:0] alu_ctl;
    logic       ld;
    logic       st;
  } ctrl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // Main instance (default parameters) signals.
  logic [1:0]  result_select, immediate_select;
  logic        PC_select, ALU_select, reg_write, mem_load, mem_store;
  logic [2:0]  ALU_control;
  logic [31:0] mem_read_data, mem_address, mem_write_data, instruction, PC, ALU_result;
  logic        mem_ready, mem_request, mem_write, zero, retire;
  ctrl_t       ctl;

  // 64-bit instance with a reset PC just below the wrap point.
  logic [63:0] mem_address64, mem_write_data64, pc64, alu_result64;
  logic [31:0] instruction64;
  logic        mem_request64, mem_write64, zero64, retire64;

  // 16-register instance running its own tiny program.
  logic [31:0] mem_read_data16, mem_address16, mem_write_data16, instruction16, pc16, alu_result16;
  logic        mem_request16, mem_write16, zero16, retire16;
  ctrl_t       ctl16;

  logic [31:0] mem [256];
  int          stall_cycles = 0;
  int          wait_cnt;
  int          st_count;
  logic [31:0] st_addr, st_data;
  int          vec_count = 0;
  int          miss_count = 0;

  // Decoder for addi-style OP-IMM, lw, sw, beq, R-type add/sub/slt/and/or, jal.
  function automatic ctrl_t decode(input logic [31:0] ins, input logic z);
    ctrl_t c;
    c = '0;
    case (ins[6:0])
      7'b0010011: begin c.alu_sel = 1'b1; c.reg_wr = 1'b1; end
      7'b0000011: begin c.alu_sel = 1'b1; c.reg_wr = 1'b1; c.ld = 1'b1; c.res_sel = 2'b01; end
      7'b0100011: begin c.alu_sel = 1'b1; c.st = 1'b1; c.imm_sel = 2'b01; end
      7'b1100011: begin c.alu_ctl = 3'b001; c.imm_sel = 2'b10; c.pc_sel = z; end
      7'b1101111: begin c.imm_sel = 2'b11; c.pc_sel = 1'b1; c.reg_wr = 1'b1; c.res_sel = 2'b10; end
      7'b0110011: begin
        c.reg_wr = 1'b1;
        case (ins[14:12])
          3'b000:  c.alu_ctl = ins[30] ? 3'b001 : 3'b000;
          3'b010:  c.alu_ctl = 3'b101;
          3'b110:  c.alu_ctl = 3'b011;
          3'b111:  c.alu_ctl = 3'b010;
          default: c.alu_ctl = 3'b111;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] rom16(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0030_0893;   // addi x17,x0,3 (lands in x1)
      32'h4:   return 32'h0010_2423;   // sw x1,8(x0)
      default: return 32'h0000_0013;
    endcase
  endfunction

  assign ctl              = decode(instruction, zero);
  assign result_select    = ctl.res_sel;
  assign PC_select        = ctl.pc_sel;
  assign ALU_select       = ctl.alu_sel;
  assign reg_write        = ctl.reg_wr;
  assign immediate_select = ctl.imm_sel;
  assign ALU_control      = ctl.alu_ctl;
  assign mem_load         = ctl.ld;
  assign mem_store        = ctl.st;
  assign mem_read_data    = mem[mem_address[9:2]];
  assign mem_ready        = mem_request && (wait_cnt >= stall_cycles);

  assign ctl16            = decode(instruction16, zero16);
  assign mem_read_data16  = rom16(mem_address16);

  // Wait-state counter and store capture for the main instance's memory.
  always @(posedge clock) begin
    if (reset || !mem_request || mem_ready) wait_cnt <= 0;
    else                                    wait_cnt <= wait_cnt + 1;
    if (reset) st_count <= 0;
    else if (mem_request && mem_ready && mem_write) begin
      st_count <= st_count + 1;
      st_addr  <= mem_address;
      st_data  <= mem_write_data;
    end
  end

  multicycle_datapath dut (
    .clock(clock), .reset(reset),
    .result_select(result_select), .PC_select(PC_select), .ALU_select(ALU_select),
    .reg_write(reg_write), .immediate_select(immediate_select), .ALU_control(ALU_control),
    .mem_load(mem_load), .mem_store(mem_store), .mem_read_data(mem_read_data),
    .mem_ready(mem_ready), .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .instruction(instruction),
    .zero(zero), .PC(PC), .ALU_result(ALU_result), .retire(retire)
  );

  multicycle_datapath #(.XLEN(64), .REG_COUNT(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut64 (
    .clock(clock), .reset(reset),
    .result_select(2'b00), .PC_select(1'b0), .ALU_select(1'b1),
    .reg_write(1'b1), .immediate_select(2'b00), .ALU_control(3'b000),
    .mem_load(1'b0), .mem_store(1'b0), .mem_read_data(64'h13),
    .mem_ready(1'b1), .mem_request(mem_request64), .mem_write(mem_write64),
    .mem_address(mem_address64), .mem_write_data(mem_write_data64), .instruction(instruction64),
    .zero(zero64), .PC(pc64), .ALU_result(alu_result64), .retire(retire64)
  );

  multicycle_datapath #(.XLEN(32), .REG_COUNT(16), .RESET_PC(32'h0)) dut16 (
    .clock(clock), .reset(reset),
    .result_select(ctl16.res_sel), .PC_select(ctl16.pc_sel), .ALU_select(ctl16.alu_sel),
    .reg_write(ctl16.reg_wr), .immediate_select(ctl16.imm_sel), .ALU_control(ctl16.alu_ctl),
    .mem_load(ctl16.ld), .mem_store(ctl16.st), .mem_read_data(mem_read_data16),
    .mem_ready(1'b1), .mem_request(mem_request16), .mem_write(mem_write16),
    .mem_address(mem_address16), .mem_write_data(mem_write_data16), .instruction(instruction16),
    .zero(zero16), .PC(pc16), .ALU_result(alu_result16), .retire(retire16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Holds reset for two edges, checking the gated outputs while it is high.
  // Returns just after the falling edge of the first post-reset cycle.
  task automatic applyStimulus();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("req_in_reset", mem_request, 0);
    checkOutput("wr_in_reset", mem_write, 0);
    checkOutput("retire_in_reset", retire, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic loadNops();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  logic [31:0] alu_expect [7];

  initial begin
    $display("[TB] starting multicycle_datapath bench");

    // Reset, addi x1,x0,5 then sw x1,8(x0); side instances run alongside.
    loadNops();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_2423;
    applyStimulus();
    checkOutput("c1_req", mem_request, 1);
    checkOutput("c1_addr", mem_address, 0);
    checkOutput("c1_pc", PC, 0);
    checkOutput("c1_ir_reset", instruction, 32'h13);
    checkOutput("c1_alu_reset", ALU_result, 0);
    checkOutput("c1_pc64", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("c1_addr64", mem_address64, 64'hFFFF_FFFF_FFFF_FFFC);
    advance(1);
    checkOutput("c2_ir", instruction, 32'h0050_0093);
    checkOutput("c2_retire", retire, 0);
    advance(1);
    checkOutput("c3_retire", retire, 1);
    checkOutput("c3_alu", ALU_result, 5);
    advance(1);
    checkOutput("c4_pc", PC, 4);
    checkOutput("c4_pc64_wrap", pc64, 0);
    advance(2);
    checkOutput("c6_write", mem_write, 1);
    checkOutput("c6_addr", mem_address, 8);
    checkOutput("c6_wdata", mem_write_data, 5);
    checkOutput("c6_write16", mem_write16, 1);
    checkOutput("c6_addr16", mem_address16, 8);
    checkOutput("c6_wdata16", mem_write_data16, 3);
    advance(1);
    checkOutput("c7_retire", retire, 1);
    checkOutput("c7_st_count", st_count, 1);
    checkOutput("c7_st_data", st_data, 5);
    checkOutput("c7_st_addr", st_addr, 8);
    advance(1);
    checkOutput("c8_pc", PC, 8);

    // Three wait states on the first fetch.
    stall_cycles = 3;
    applyStimulus();
    advance(2);
    checkOutput("ws_c3_req", mem_request, 1);
    checkOutput("ws_c3_addr", mem_address, 0);
    checkOutput("ws_c3_ir", instruction, 32'h13);
    advance(1);
    checkOutput("ws_c4_ir", instruction, 32'h13);
    advance(1);
    checkOutput("ws_c5_ir", instruction, 32'h0050_0093);
    checkOutput("ws_c5_retire", retire, 0);
    advance(1);
    checkOutput("ws_c6_retire", retire, 1);
    stall_cycles = 0;

    // beq x1,x2,+16 at 0x10 with equal and unequal operands.
    for (int pass = 0; pass < 2; pass++) begin
      loadNops();
      mem[0] = 32'h0070_0093;
      mem[1] = (pass == 0) ? 32'h0070_0113 : 32'h0080_0113;
      mem[4] = 32'h0020_8863;
      applyStimulus();
      advance(12);
      checkOutput("br_pc_before", PC, 32'h10);
      advance(2);
      checkOutput("br_zero", zero, (pass == 0) ? 1 : 0);
      checkOutput("br_retire", retire, 1);
      advance(1);
      checkOutput("br_pc_after", PC, (pass == 0) ? 32'h20 : 32'h14);
    end

    // Load from 0x40, store it back, and store x0 after writing x0.
    loadNops();
    mem[0]  = 32'h0400_2183;
    mem[1]  = 32'h0430_2223;
    mem[2]  = 32'h0090_0013;
    mem[3]  = 32'h0400_2423;
    mem[16] = 32'hDEAD_BEEF;
    applyStimulus();
    advance(2);
    checkOutput("ld_addr", mem_address, 32'h40);
    checkOutput("ld_write", mem_write, 0);
    checkOutput("ld_req", mem_request, 1);
    advance(1);
    checkOutput("ld_retire", retire, 1);
    advance(3);
    checkOutput("sw3_write", mem_write, 1);
    checkOutput("sw3_addr", mem_address, 32'h44);
    checkOutput("sw3_data", mem_write_data, 32'hDEAD_BEEF);
    advance(7);
    checkOutput("sw0_addr", mem_address, 32'h48);
    checkOutput("sw0_data", mem_write_data, 0);
    advance(1);
    checkOutput("ld_st_count", st_count, 2);

    // ALU operations: x1=5, x2=-3, then slt both ways, sub, and, or.
    loadNops();
    mem[0] = 32'h0050_0093;  alu_expect[0] = 32'h5;
    mem[1] = 32'hFFD0_0113;  alu_expect[1] = 32'hFFFF_FFFD;
    mem[2] = 32'h0020_A1B3;  alu_expect[2] = 32'h0;
    mem[3] = 32'h0011_23B3;  alu_expect[3] = 32'h1;
    mem[4] = 32'h4020_8233;  alu_expect[4] = 32'h8;
    mem[5] = 32'h0020_F2B3;  alu_expect[5] = 32'h5;
    mem[6] = 32'h0020_E333;  alu_expect[6] = 32'hFFFF_FFFD;
    applyStimulus();
    for (int k = 0; k < 7; k++) begin
      advance((k == 0) ? 2 : 3);
      checkOutput($sformatf("alu_op%0d", k), ALU_result, alu_expect[k]);
    end

    // Reset raised while a stalled store sits in MEMORY.
    loadNops();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_2423;
    stall_cycles = 2;
    applyStimulus();
    advance(9);
    checkOutput("mid_req", mem_request, 1);
    checkOutput("mid_write", mem_write, 1);
    checkOutput("mid_addr", mem_address, 8);
    applyStimulus();
    checkOutput("mid_pc_after", PC, 0);
    checkOutput("mid_ir_after", instruction, 32'h13);
    checkOutput("mid_addr_after", mem_address, 0);
    stall_cycles = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
